// File: rtl/memory_port_arbiter_if.sv
// Signal bundle between the unified-memory-port arbiter, its two clients
// (instruction fetch and the Memory stage) and the memory bus.
// The master view belongs to the arbiter; the slave view is the environment around it.
interface memory_port_arbiter_if;

   // Fetch side
   logic        fetchRequest;
   logic [31:0] fetchAddress;
   logic        fetchFlush;
   logic        fetchResponseValid;
   logic [31:0] fetchData;

   // Memory stage side
   logic        loadRequest;
   logic        storeValid;
   logic [31:0] dataAddress;
   logic [31:0] storeData;
   logic [3:0]  realStoreByteEnable;
   logic        loadDataValid;
   logic [31:0] loadData;
   logic        storeComplete;

   // Memory bus side
   logic        memRequest;
   logic        memWrite;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic [3:0]  memByteEnable;
   logic        memReady;
   logic        memResponseValid;
   logic [31:0] memReadData;

   modport master (
      input  fetchRequest, fetchAddress, fetchFlush,
      input  loadRequest, storeValid, dataAddress, storeData, realStoreByteEnable,
      input  memReady, memResponseValid, memReadData,
      output fetchResponseValid, fetchData,
      output loadDataValid, loadData, storeComplete,
      output memRequest, memWrite, memAddress, memWriteData, memByteEnable
   );

   modport slave (
      output fetchRequest, fetchAddress, fetchFlush,
      output loadRequest, storeValid, dataAddress, storeData, realStoreByteEnable,
      output memReady, memResponseValid, memReadData,
      input  fetchResponseValid, fetchData,
      input  loadDataValid, loadData, storeComplete,
      input  memRequest, memWrite, memAddress, memWriteData, memByteEnable
   );

endinterface

// File: rtl/memory_port_arbiter.sv
// Shares the single memory port between instruction fetch and the Memory stage.
// Data requests beat fetch, except that after MaxDataStreak consecutive data grants with a
// fetch waiting, fetch is forced through. Only one bus transaction is ever outstanding, and
// a flushed fetch response is swallowed rather than forwarded.
module memory_port_arbiter #(
   parameter int unsigned MaxDataStreak = 4
) (
   input logic                   clock,
   input logic                   reset,
   memory_port_arbiter_if.master bus
);

   localparam int unsigned StreakWidth = $clog2(MaxDataStreak + 1);
   localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxDataStreak);

   typedef enum logic [2:0] {
      Idle,
      IssueFetch,
      IssueData,
      WaitFetch,
      WaitData
   } state_t;

   state_t                 state;
   logic [StreakWidth-1:0] streak;
   logic                   discard;

   // Registered bus outputs, latched at grant and held until memReady
   logic                   mem_request;
   logic                   mem_write;
   logic [31:0]            mem_address;
   logic [31:0]            mem_write_data;
   logic [3:0]             mem_byte_enable;

   logic                   data_pending;
   logic                   fetch_forced;
   logic                   grant_data;
   logic                   grant_fetch;
   logic [StreakWidth-1:0] streak_next;
   logic                   load_response;
   logic                   fetch_response;

   // The low address bits are dropped on purpose: the bus is word addressed
   logic                   unused_addr_bits;
   assign unused_addr_bits = ^{bus.fetchAddress[1:0], bus.dataAddress[1:0]};

   // Arbitration decision for the current IDLE cycle and the streak that follows a data grant
   always_comb begin
      data_pending = bus.loadRequest | bus.storeValid;
      fetch_forced = bus.fetchRequest && (streak == StreakMax);
      grant_data   = (state == Idle) && data_pending && !fetch_forced;
      grant_fetch  = (state == Idle) && !grant_data && bus.fetchRequest;
      streak_next  = '0;
      if (bus.fetchRequest) begin
         streak_next = (streak == StreakMax) ? streak : streak + StreakWidth'(1);
      end
   end

   // Response pulses are combinational so the client sees the word in the bus response cycle
   always_comb begin
      load_response  = (state == WaitData) && bus.memResponseValid;
      fetch_response = (state == WaitFetch) && bus.memResponseValid;

      bus.loadDataValid      = load_response;
      bus.loadData           = load_response ? bus.memReadData : '0;
      // A flush landing on the response cycle still kills the response
      bus.fetchResponseValid = fetch_response && !discard && !bus.fetchFlush;
      bus.fetchData          = bus.fetchResponseValid ? bus.memReadData : '0;
      // Stores complete on acceptance; there is no write response on the bus
      bus.storeComplete      = (state == IssueData) && mem_write && bus.memReady;

      bus.memRequest    = mem_request;
      bus.memWrite      = mem_write;
      bus.memAddress    = mem_address;
      bus.memWriteData  = mem_write_data;
      bus.memByteEnable = mem_byte_enable;
   end

   // Transaction FSM with registered bus outputs; reset abandons any transaction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= Idle;
         streak          <= '0;
         discard         <= 1'b0;
         mem_request     <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_write_data  <= '0;
         mem_byte_enable <= '0;
      end else begin
         unique case (state)
            Idle: begin
               if (grant_data) begin
                  // A simultaneous load and store is illegal upstream; the store is taken
                  state           <= IssueData;
                  streak          <= streak_next;
                  mem_request     <= 1'b1;
                  mem_write       <= bus.storeValid;
                  mem_address     <= {bus.dataAddress[31:2], 2'b00};
                  mem_write_data  <= bus.storeValid ? bus.storeData : '0;
                  mem_byte_enable <= bus.storeValid ? bus.realStoreByteEnable : 4'b1111;
               end else if (grant_fetch) begin
                  state           <= IssueFetch;
                  streak          <= '0;
                  discard         <= 1'b0;
                  mem_request     <= 1'b1;
                  mem_write       <= 1'b0;
                  mem_address     <= {bus.fetchAddress[31:2], 2'b00};
                  mem_write_data  <= '0;
                  mem_byte_enable <= 4'b1111;
               end
            end

            IssueData: begin
               if (bus.memReady) begin
                  state           <= mem_write ? Idle : WaitData;
                  mem_request     <= 1'b0;
                  mem_write       <= 1'b0;
                  mem_address     <= '0;
                  mem_write_data  <= '0;
                  mem_byte_enable <= '0;
               end
            end

            IssueFetch: begin
               if (bus.fetchFlush) begin
                  discard <= 1'b1;
               end
               if (bus.memReady) begin
                  state           <= WaitFetch;
                  mem_request     <= 1'b0;
                  mem_write       <= 1'b0;
                  mem_address     <= '0;
                  mem_write_data  <= '0;
                  mem_byte_enable <= '0;
               end
            end

            WaitData: begin
               if (bus.memResponseValid) begin
                  state <= Idle;
               end
            end

            WaitFetch: begin
               if (bus.memResponseValid) begin
                  state   <= Idle;
                  discard <= 1'b0;
               end else if (bus.fetchFlush) begin
                  discard <= 1'b1;
               end
            end

            default: begin
               state <= Idle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: stimulus queues the expected bus grants and
// client responses (with cycle gaps between consecutive events), a monitor pops and
// compares whenever the arbiter presents one, and a bus model answers requests.
module tb_memory_port_arbiter;

   localparam int unsigned MaxDataStreak = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   memory_port_arbiter_if bus ();

   memory_port_arbiter #(
      .MaxDataStreak(MaxDataStreak)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef enum int {EvGrant, EvFetch, EvLoad, EvStore} ev_kind_t;

   typedef struct {
      ev_kind_t    kind;
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
      int          gap;   // cycles since the previous event, -1 = not checked
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_fail = 0;
   int  cycle = 0;
   int  last_cyc = -1;
   int  resp_extra = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic exp_grant(input logic [31:0] addr, input logic wr, input logic [3:0] be,
                            input logic [31:0] wdata, input int gap);
      exp_q.push_back('{kind: EvGrant, addr: addr, wr: wr, be: be, data: wdata, gap: gap});
   endtask

   task automatic exp_done(input ev_kind_t kind, input logic [31:0] data, input int gap);
      exp_q.push_back('{kind: kind, addr: 32'h0, wr: 1'b0, be: 4'h0, data: data, gap: gap});
   endtask

   // Bus memory contents
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0100: return 32'h0000_0013;
         32'h0000_0080: return 32'hDEAD_BEEF;
         32'h0000_0040: return 32'h0010_0093;
         32'h0000_0010: return 32'hCAFE_0010;
         32'h0000_0300: return 32'h0000_0073;
         default:       return 32'h0;
      endcase
   endfunction

   task automatic observe(input ev_kind_t kind, input logic [31:0] addr, input logic wr,
                          input logic [3:0] be, input logic [31:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_event: got %s data %h, expected none (cycle %0d)",
                  kind.name(), data, cycle);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (e.kind == EvGrant) begin
            check("memAddress", addr, e.addr);
            check("memWrite", 32'(wr), 32'(e.wr));
            check("memByteEnable", 32'(be), 32'(e.be));
         end
         check({kind.name(), "_data"}, data, e.data);
         if (e.gap >= 0 && last_cyc >= 0) begin
            check({kind.name(), "_gap"}, 32'(cycle - last_cyc), 32'(e.gap));
         end
      end
      last_cyc = cycle;
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   initial begin : monitor
      logic        prev_req;
      logic        prev_wr;
      logic [31:0] prev_addr;
      logic [31:0] prev_wdata;
      logic [3:0]  prev_be;
      prev_req = 1'b0;
      prev_wr = 1'b0;
      prev_addr = '0;
      prev_wdata = '0;
      prev_be = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_req = 1'b0;
            last_cyc = -1;
         end else begin
            if (bus.memRequest && prev_req) begin
               check("hold_memAddress", bus.memAddress, prev_addr);
               check("hold_memWrite", 32'(bus.memWrite), 32'(prev_wr));
               check("hold_memByteEnable", 32'(bus.memByteEnable), 32'(prev_be));
               check("hold_memWriteData", bus.memWriteData, prev_wdata);
            end
            if (bus.memRequest && !prev_req) begin
               observe(EvGrant, bus.memAddress, bus.memWrite, bus.memByteEnable,
                       bus.memWriteData);
            end
            if (bus.storeComplete) observe(EvStore, '0, 1'b0, '0, '0);
            if (bus.loadDataValid) observe(EvLoad, '0, 1'b0, '0, bus.loadData);
            if (bus.fetchResponseValid) observe(EvFetch, '0, 1'b0, '0, bus.fetchData);
            prev_req   = bus.memRequest;
            prev_wr    = bus.memWrite;
            prev_addr  = bus.memAddress;
            prev_wdata = bus.memWriteData;
            prev_be    = bus.memByteEnable;
         end
      end
   end

   // Bus model: memReady in the second request cycle, read data resp_extra cycles after that
   initial begin : bus_model
      int          age;
      int          wait_cnt;
      logic        pend;
      logic        hs_write;
      logic [31:0] hs_addr;
      logic [31:0] pend_data;
      age = 0;
      wait_cnt = 0;
      pend = 1'b0;
      hs_write = 1'b0;
      hs_addr = '0;
      pend_data = '0;
      bus.memReady = 1'b0;
      bus.memResponseValid = 1'b0;
      bus.memReadData = '0;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            bus.memReady = 1'b0;
            bus.memResponseValid = 1'b0;
            bus.memReadData = '0;
            age = 0;
            pend = 1'b0;
         end else begin
            if (bus.memResponseValid) begin
               bus.memResponseValid = 1'b0;
               bus.memReadData = '0;
            end
            if (bus.memReady) begin
               bus.memReady = 1'b0;
               age = 0;
               if (!hs_write) begin
                  pend = 1'b1;
                  wait_cnt = resp_extra;
                  pend_data = mem_word(hs_addr);
               end
            end else if (bus.memRequest) begin
               age++;
               if (age == 2) begin
                  bus.memReady = 1'b1;
                  hs_write = bus.memWrite;
                  hs_addr = bus.memAddress;
               end
            end
            if (pend) begin
               if (wait_cnt == 0) begin
                  bus.memResponseValid = 1'b1;
                  bus.memReadData = pend_data;
                  pend = 1'b0;
               end else begin
                  wait_cnt--;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         assert (!(bus.loadRequest && bus.storeValid))
         else $error("loadRequest and storeValid asserted together");
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic wait_ev(input ev_kind_t k, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step(1);
         case (k)
            EvFetch: seen = bus.fetchResponseValid;
            EvLoad:  seen = bus.loadDataValid;
            EvStore: seen = bus.storeComplete;
            default: seen = bus.memRequest;
         endcase
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: %s not seen within %0d cycles, required within budget",
                  k.name(), budget);
      end
   endtask

   task automatic drain(input string name);
      step(3);
      check({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.fetchRequest = 1'b0;
      bus.fetchAddress = '0;
      bus.fetchFlush = 1'b0;
      bus.loadRequest = 1'b0;
      bus.storeValid = 1'b0;
      bus.dataAddress = '0;
      bus.storeData = '0;
      bus.realStoreByteEnable = '0;
      reset = 1'b1;
      step(3);

      // Reset state
      check("rst_memRequest", 32'(bus.memRequest), 32'd0);
      check("rst_memWrite", 32'(bus.memWrite), 32'd0);
      check("rst_memAddress", bus.memAddress, 32'd0);
      check("rst_memByteEnable", 32'(bus.memByteEnable), 32'd0);
      check("rst_memWriteData", bus.memWriteData, 32'd0);
      check("rst_fetchResponseValid", 32'(bus.fetchResponseValid), 32'd0);
      check("rst_loadDataValid", 32'(bus.loadDataValid), 32'd0);
      check("rst_storeComplete", 32'(bus.storeComplete), 32'd0);
      reset = 1'b0;
      step(2);

      // Plain fetch
      exp_grant(32'h100, 1'b0, 4'b1111, 32'h0, -1);
      exp_done(EvFetch, 32'h0000_0013, 2);
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h100;
      wait_ev(EvFetch, 10);
      bus.fetchRequest = 1'b0;
      drain("fetch");

      // Byte store, unaligned address
      exp_grant(32'h200, 1'b1, 4'b0100, 32'h00AB_0000, -1);
      exp_done(EvStore, 32'h0, 1);
      bus.storeValid = 1'b1;
      bus.dataAddress = 32'h202;
      bus.storeData = 32'h00AB_0000;
      bus.realStoreByteEnable = 4'b0100;
      wait_ev(EvStore, 10);
      bus.storeValid = 1'b0;
      drain("store");

      // Continuous fetch and load: D,D,D,D,F,D,D,D,D,F
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            exp_grant(32'h300, 1'b0, 4'b1111, 32'h0, (k == 0) ? -1 : 2);
            exp_done(EvFetch, 32'h0000_0073, 2);
         end else begin
            exp_grant(32'h10, 1'b0, 4'b1111, 32'h0, (k == 0) ? -1 : 2);
            exp_done(EvLoad, 32'hCAFE_0010, 2);
         end
      end
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h300;
      bus.loadRequest = 1'b1;
      bus.dataAddress = 32'h10;
      wait_ev(EvFetch, 60);
      wait_ev(EvFetch, 60);
      bus.fetchRequest = 1'b0;
      bus.loadRequest = 1'b0;
      drain("streak");

      // Flush while waiting for the fetch response
      resp_extra = 2;
      exp_grant(32'h80, 1'b0, 4'b1111, 32'h0, -1);
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h80;
      step(3);
      bus.fetchFlush = 1'b1;
      bus.fetchRequest = 1'b0;
      step(1);
      bus.fetchFlush = 1'b0;
      step(4);
      check("flush_pending_events", 32'(exp_q.size()), 32'd0);
      resp_extra = 0;

      // Next fetch after a discarded one returns normally
      exp_grant(32'h40, 1'b0, 4'b1111, 32'h0, -1);
      exp_done(EvFetch, 32'h0010_0093, 2);
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h40;
      wait_ev(EvFetch, 10);
      bus.fetchRequest = 1'b0;
      drain("post_flush");

      // Flush in the same cycle as the response
      exp_grant(32'h80, 1'b0, 4'b1111, 32'h0, -1);
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h80;
      step(3);
      bus.fetchFlush = 1'b1;
      bus.fetchRequest = 1'b0;
      step(1);
      bus.fetchFlush = 1'b0;
      drain("flush_on_response");

      // Load and fetch arrive together: load first, fetch after one IDLE cycle
      exp_grant(32'h10, 1'b0, 4'b1111, 32'h0, -1);
      exp_done(EvLoad, 32'hCAFE_0010, 2);
      exp_grant(32'h40, 1'b0, 4'b1111, 32'h0, 2);
      exp_done(EvFetch, 32'h0010_0093, 2);
      bus.loadRequest = 1'b1;
      bus.dataAddress = 32'h10;
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h40;
      wait_ev(EvLoad, 10);
      bus.loadRequest = 1'b0;
      wait_ev(EvFetch, 10);
      bus.fetchRequest = 1'b0;
      drain("data_first");

      // Reset in WAIT_DATA with a nonzero streak
      resp_extra = 5;
      exp_grant(32'h10, 1'b0, 4'b1111, 32'h0, -1);
      bus.loadRequest = 1'b1;
      bus.dataAddress = 32'h10;
      bus.fetchRequest = 1'b1;
      bus.fetchAddress = 32'h300;
      step(3);
      reset = 1'b1;
      bus.loadRequest = 1'b0;
      step(1);
      check("rstwait_memRequest", 32'(bus.memRequest), 32'd0);
      check("rstwait_loadDataValid", 32'(bus.loadDataValid), 32'd0);
      check("rstwait_memAddress", bus.memAddress, 32'd0);
      check("rstwait_fetchResponseValid", 32'(bus.fetchResponseValid), 32'd0);
      resp_extra = 0;
      // Streak restarts from zero: four loads before the forced fetch
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            exp_grant(32'h300, 1'b0, 4'b1111, 32'h0, 2);
            exp_done(EvFetch, 32'h0000_0073, 2);
         end else begin
            exp_grant(32'h10, 1'b0, 4'b1111, 32'h0, (k == 0) ? -1 : 2);
            exp_done(EvLoad, 32'hCAFE_0010, 2);
         end
      end
      bus.loadRequest = 1'b1;
      reset = 1'b0;
      wait_ev(EvFetch, 40);
      bus.loadRequest = 1'b0;
      bus.fetchRequest = 1'b0;
      drain("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch and the Memory pipeline stage (loads/stores).
- Sits between the fetch unit, the Memory stage (storeValid/storeComplete, loadData/loadDataValid) and the memory bus.
- Fixed data-over-fetch priority plus a starvation limit; one outstanding transaction; supports discarding flushed fetch responses.

Parameters:
- MaxDataStreak, 4: max consecutive data grants while fetchRequest is pending before fetch is forced to win (≥1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetchRequest  in  1  level; held until fetchResponseValid or fetchFlush
- fetchAddress  in  32  word-aligned fetch address
- fetchFlush  in  1  pulse; discard in-flight/issued fetch
- fetchResponseValid  out  1  fetched word valid, 1-cycle pulse
- fetchData  out  32  fetched word
- loadRequest  in  1  level; Memory stage load pending
- storeValid  in  1  level; Memory stage store pending
- dataAddress  in  32  load/store byte address
- storeData  in  32  lane-aligned store data
- realStoreByteEnable  in  4  store byte enables
- loadDataValid  out  1  load word valid, 1-cycle pulse
- loadData  out  32  raw loaded word
- storeComplete  out  1  store accepted, 1-cycle pulse
- memRequest  out  1  bus request, held until memReady
- memWrite  out  1  1 = store
- memAddress  out  32  word address ({addr[31:2],2'b00})
- memWriteData  out  32  store data
- memByteEnable  out  4  byte enables (4'b1111 on reads)
- memReady  in  1  bus accepts request this cycle
- memResponseValid  in  1  read data valid (reads only)
- memReadData  in  32  read data

Behaviour:
- State register: IDLE, ISSUE_FETCH, ISSUE_DATA, WAIT_FETCH, WAIT_DATA. Reset → IDLE, streak=0, discard=0; all outputs 0.
- All mem* outputs are registered and latched at grant; they remain stable while memRequest=1 (request is never retracted).
- IDLE arbitration, evaluated each cycle:
  - Data (loadRequest|storeValid) wins unless fetchRequest=1 and streak==MaxDataStreak.
  - Otherwise fetch wins if fetchRequest=1.
  - Grant → ISSUE_x next cycle with memRequest=1 (1-cycle grant latency).
- Both loadRequest and storeValid high: illegal (bench assertion); store is taken.
- streak: +1 on each data grant while fetchRequest=1; cleared on fetch grant or when fetchRequest=0 at a data grant; saturates at MaxDataStreak.
- ISSUE_DATA + memReady:
  - store → storeComplete pulse that same cycle, memRequest falls next cycle → IDLE.
  - load → WAIT_DATA.
- ISSUE_FETCH + memReady → WAIT_FETCH.
- WAIT_DATA + memResponseValid:
  - Combinational loadDataValid=1 and loadData=memReadData in that cycle → IDLE.
  - The pulse is generated even if loadRequest has since dropped.
- WAIT_FETCH + memResponseValid:
  - fetchResponseValid=1 and fetchData=memReadData unless discard=1 (response swallowed, no pulse).
  - → IDLE, discard cleared.
- fetchFlush in ISSUE_FETCH or WAIT_FETCH sets discard. If fetchFlush coincides with memResponseValid in WAIT_FETCH, the response is discarded. fetchFlush in IDLE/data states: no effect.
- memResponseValid outside WAIT_x is ignored. Bus contract: response no earlier than the cycle after memReady.
- One IDLE bubble after every transaction; max throughput is 1 transaction per 3 cycles with memReady and response at minimum latency.
- Reset mid-transaction abandons it immediately; the bus is reset by the same signal.

Test Plan:
- Fetch only, addr 0x100, memReady 1 cycle after memRequest, response 1 cycle later, data 0x00000013 → memAddress=0x100, memByteEnable=4'b1111, fetchResponseValid pulse with 0x00000013, 1 cycle.
- Store at 0x202, byte enables 4'b0100, data 0x00AB0000 → memWrite=1, memAddress=0x200, storeComplete pulse in the memReady cycle, no loadDataValid.
- Fetch and load both requested continuously, MaxDataStreak=4 → grant order D,D,D,D,F,D,D,D,D,F; streak resets after each F.
- fetchFlush during WAIT_FETCH, then response 0xDEADBEEF → no fetchResponseValid; next fetch to 0x40 returns normally.
- Load to 0x10 arriving in the same cycle as a fetch request in IDLE → data granted first; fetch issued after the loadDataValid pulse plus one IDLE cycle.
- reset asserted in WAIT_DATA → next cycle IDLE, memRequest=0, loadDataValid=0, streak=0.
